// File: rtl/skiroc_sc_loader_if.sv
// Handshake bundle between the TA-scan controller and the SKIROC2 slow-control loader.
// The master modport belongs to the scan controller and the slave modport to the loader.
interface skiroc_sc_loader_if;
  logic         In_Set_SC;
  logic [47:0]  In_Set_DAC;
  logic [255:0] In_Mask_Code;
  logic         Out_Finish_Sc;
  logic         Out_Busy;

  modport master (
    output In_Set_SC,
    output In_Set_DAC,
    output In_Mask_Code,
    input  Out_Finish_Sc,
    input  Out_Busy
  );

  modport slave (
    input  In_Set_SC,
    input  In_Set_DAC,
    input  In_Mask_Code,
    output Out_Finish_Sc,
    output Out_Busy
  );
endinterface

// File: rtl/skiroc_sc_loader.sv
// SKIROC2 slow-control loader. A Set_SC rising edge seen while idle snapshots the
// 48-bit DAC word and the 256-bit mask. The loader then resets the chip SC register,
// shifts the 304-bit frame out MSB first on Sr_Ck/Sr_In, strobes Load_SC, and reports
// Finish_Sc. Every output is driven straight from a register.
module skiroc_sc_loader #(
  parameter int unsigned HALF_PER   = 2,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned LOAD_CYC   = 4,
  parameter int unsigned FINISH_CYC = 2
) (
  input  logic               Clk_10MHz,
  input  logic               Rst,
  skiroc_sc_loader_if.slave  sc,
  output logic               Out_Sr_Ck,
  output logic               Out_Sr_In,
  output logic               Out_Sr_Rstb,
  output logic               Out_Load_SC
);

  localparam int unsigned FRAME_W = 304;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned HC_W    = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST_SR = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] FIN_LAST  = CNT_W'(FINISH_CYC - 1);
  localparam logic [HC_W-1:0]  HALF_LAST = HC_W'(HALF_PER - 1);
  localparam logic [8:0]       BIT_LAST  = 9'(FRAME_W - 1);

  logic [2:0]         r_state;
  logic               r_prev;
  logic [FRAME_W-1:0] r_frame;
  logic [CNT_W-1:0]   r_cnt;
  logic [HC_W-1:0]    r_half;
  logic               r_phase;
  logic [8:0]         r_bit;
  logic               r_sr_ck;
  logic               r_sr_in;
  logic               r_sr_rstb;
  logic               r_load;
  logic               r_finish;
  logic               r_busy;
  logic               w_start;

  // A request is only a new rising edge of Set_SC seen while idle.
  assign w_start = sc.In_Set_SC & ~r_prev & (r_state == S_IDLE);

  assign Out_Sr_Ck        = r_sr_ck;
  assign Out_Sr_In        = r_sr_in;
  assign Out_Sr_Rstb      = r_sr_rstb;
  assign Out_Load_SC      = r_load;
  assign sc.Out_Finish_Sc = r_finish;
  assign sc.Out_Busy      = r_busy;

  // Edge-detect history of Set_SC. It updates in every state, so a level held
  // through the whole load does not look like a new edge back in IDLE.
  always_ff @(posedge Clk_10MHz) begin
    if (Rst) r_prev <= 1'b0;
    else     r_prev <= sc.In_Set_SC;
  end

  // Main sequencer. The output registers are updated on the same edge as the state
  // change, so each output level lines up exactly with its state.
  always_ff @(posedge Clk_10MHz) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_cnt     <= '0;
      r_half    <= '0;
      r_phase   <= 1'b0;
      r_bit     <= '0;
      r_sr_ck   <= 1'b0;
      r_sr_in   <= 1'b0;
      r_sr_rstb <= 1'b1;
      r_load    <= 1'b0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_frame   <= {sc.In_Set_DAC, sc.In_Mask_Code};
            r_state   <= S_RST_SR;
            r_busy    <= 1'b1;
            r_sr_rstb <= 1'b0;
            r_cnt     <= '0;
          end
        end

        S_RST_SR: begin
          if (r_cnt == RST_LAST) begin
            // Leave reset and present the first bit at the start of slot 0.
            r_state   <= S_SHIFT;
            r_sr_rstb <= 1'b1;
            r_sr_ck   <= 1'b0;
            r_sr_in   <= r_frame[FRAME_W-1];
            r_half    <= '0;
            r_phase   <= 1'b0;
            r_bit     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (r_half == HALF_LAST) begin
            r_half <= '0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_sr_ck <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_sr_ck <= 1'b0;
              if (r_bit == BIT_LAST) begin
                r_state <= S_LOAD;
                r_sr_in <= 1'b0;
                r_load  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                // The frame shifts left, so the next bit always sits at FRAME_W-2.
                r_bit   <= r_bit + 9'd1;
                r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
                r_sr_in <= r_frame[FRAME_W-2];
              end
            end
          end else begin
            r_half <= r_half + 1'b1;
          end
        end

        S_LOAD: begin
          if (r_cnt == LOAD_LAST) begin
            r_state  <= S_DONE;
            r_load   <= 1'b0;
            r_finish <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (r_cnt == FIN_LAST) begin
            r_state  <= S_IDLE;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_sr_ck   <= 1'b0;
          r_sr_in   <= 1'b0;
          r_sr_rstb <= 1'b1;
          r_load    <= 1'b0;
          r_finish  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skiroc_sc_loader.sv
// Directed bench for skiroc_sc_loader. Instance 1 uses the default timing
// (HALF_PER=2) and instance 2 uses HALF_PER=1. Each instance has a chip-side
// shift-register model and per-cycle monitors on its outputs.
module tb_skiroc_sc_loader;

  localparam int FW     = 304;
  localparam int BUSY1  = 4 + FW * 2 * 2 + 4 + 2;
  localparam int BUSY2  = 4 + FW * 2 * 1 + 4 + 2;
  localparam int BOUND  = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  skiroc_sc_loader_if if1 ();
  skiroc_sc_loader_if if2 ();

  logic u1_ck, u1_in, u1_rstb, u1_load;
  logic u2_ck, u2_in, u2_rstb, u2_load;

  skiroc_sc_loader #(.HALF_PER(2), .RST_CYC(4), .LOAD_CYC(4), .FINISH_CYC(2)) u_dut1 (
    .Clk_10MHz(clk), .Rst(rst), .sc(if1),
    .Out_Sr_Ck(u1_ck), .Out_Sr_In(u1_in), .Out_Sr_Rstb(u1_rstb), .Out_Load_SC(u1_load)
  );

  skiroc_sc_loader #(.HALF_PER(1), .RST_CYC(4), .LOAD_CYC(4), .FINISH_CYC(2)) u_dut2 (
    .Clk_10MHz(clk), .Rst(rst), .sc(if2),
    .Out_Sr_Ck(u2_ck), .Out_Sr_In(u2_in), .Out_Sr_Rstb(u2_rstb), .Out_Load_SC(u2_load)
  );

  int vectors = 0;
  int miscompares = 0;

  // chip-side shift registers
  logic [FW-1:0] cap1, cap2;
  int n1 = 0, n2 = 0;
  logic samp1 = 1'b0, samp2 = 1'b0;

  always @(posedge u1_ck) begin cap1 = {cap1[FW-2:0], u1_in}; samp1 = u1_in; n1++; end
  always @(posedge u2_ck) begin cap2 = {cap2[FW-2:0], u2_in}; samp2 = u2_in; n2++; end

  // per-cycle monitors
  int cyc = 0;
  int busy1 = 0, rstlo1 = 0, load1 = 0, fin1 = 0, busy_r1 = 0, load_r1 = 0, fin_r1 = 0;
  int load_last1 = 0, fin_first1 = 0, viol1 = 0;
  int busy2 = 0, rstlo2 = 0, ckhi2 = 0, viol2 = 0;
  logic bp1 = 1'b0, lp1 = 1'b0, fp1 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (if1.Out_Busy === 1'b1) begin busy1++; if (!bp1) busy_r1++; end
    if (u1_rstb === 1'b0) rstlo1++;
    if (u1_load === 1'b1) begin load1++; load_last1 = cyc; if (!lp1) load_r1++; end
    if (if1.Out_Finish_Sc === 1'b1) begin fin1++; if (!fp1) begin fin_r1++; fin_first1 = cyc; end end
    if (u1_ck === 1'b1 && u1_in !== samp1) viol1++;
    bp1 = (if1.Out_Busy === 1'b1);
    lp1 = (u1_load === 1'b1);
    fp1 = (if1.Out_Finish_Sc === 1'b1);
    if (if2.Out_Busy === 1'b1) busy2++;
    if (u2_rstb === 1'b0) rstlo2++;
    if (u2_ck === 1'b1) ckhi2++;
    if (u2_ck === 1'b1 && u2_in !== samp2) viol2++;
  end

  task automatic clear_stats();
    busy1 = 0; rstlo1 = 0; load1 = 0; fin1 = 0; busy_r1 = 0; load_r1 = 0; fin_r1 = 0;
    load_last1 = 0; fin_first1 = 0; viol1 = 0; n1 = 0;
    busy2 = 0; rstlo2 = 0; ckhi2 = 0; viol2 = 0; n2 = 0;
  endtask

  task automatic wait_idle1(input string nm);
    int k = 0;
    @(negedge clk);
    while (if1.Out_Busy !== 1'b0 && k < BOUND) begin @(negedge clk); k++; end
    if (k >= BOUND) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout waiting for Busy low, got busy=%b required 0", nm, if1.Out_Busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle2(input string nm);
    int k = 0;
    @(negedge clk);
    while (if2.Out_Busy !== 1'b0 && k < BOUND) begin @(negedge clk); k++; end
    if (k >= BOUND) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout waiting for Busy low, got busy=%b required 0", nm, if2.Out_Busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bits1(input int nb, input string nm);
    int k = 0;
    while (n1 < nb && k < BOUND) begin @(negedge clk); k++; end
    if (k >= BOUND) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout waiting for %0d Sr_Ck edges, got %0d", nm, nb, n1);
    end
  endtask

  task automatic pulse1();
    if1.In_Set_SC = 1'b1; @(negedge clk); if1.In_Set_SC = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    if1.In_Set_SC = 1'b1; if2.In_Set_SC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {u1_ck, u1_in, u1_rstb, u1_load, if1.Out_Finish_Sc, if1.Out_Busy};
      vectors++;
      if (obs !== 6'b001000) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %b required 001000", i, obs);
      end
    end
    rst = 1'b0; if1.In_Set_SC = 1'b0; if2.In_Set_SC = 1'b0;
    clear_stats();
    repeat (4) @(negedge clk);
    obs = {u2_ck, u2_in, u2_rstb, u2_load, if2.Out_Finish_Sc, if2.Out_Busy};
    vectors++;
    if (obs !== 6'b001000) begin
      miscompares++;
      $display("FAIL reset_dut2: got %b required 001000", obs);
    end
    vectors++;
    if (busy_r1 !== 0 || if1.Out_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_start: busy starts %0d busy=%b required 0 and 0", busy_r1, if1.Out_Busy);
    end
  endtask

  task automatic test_frame();
    logic [FW-1:0] exp;
    if1.In_Set_DAC   = 48'hA5A_123_0FF_800;
    if1.In_Mask_Code = (256'h1 << 255) | 256'h1;
    exp = {48'hA5A_123_0FF_800, 8'h80, 240'h0, 8'h01};
    clear_stats();
    pulse1();
    wait_idle1("frame");
    vectors++;
    if (cap1 !== exp || n1 !== FW) begin
      miscompares++;
      $display("FAIL frame_data: got %0d bits %h required %0d bits %h", n1, cap1, FW, exp);
    end
    vectors++;
    if (busy1 !== BUSY1) begin
      miscompares++;
      $display("FAIL frame_busy_len: got %0d required %0d", busy1, BUSY1);
    end
    vectors++;
    if (rstlo1 !== 4) begin
      miscompares++;
      $display("FAIL frame_rstb_len: got %0d required 4", rstlo1);
    end
    vectors++;
    if (viol1 !== 0) begin
      miscompares++;
      $display("FAIL frame_sr_in_stable: got %0d changes while Sr_Ck high required 0", viol1);
    end
  endtask

  task automatic test_timing();
    logic [FW-1:0] exp;
    if2.In_Set_DAC   = 48'h123_456_789_ABC;
    if2.In_Mask_Code = {8{32'hDEAD_BEEF}};
    exp = {48'h123_456_789_ABC, {8{32'hDEAD_BEEF}}};
    clear_stats();
    if2.In_Set_SC = 1'b1; @(negedge clk); if2.In_Set_SC = 1'b0;
    wait_idle2("timing");
    vectors++;
    if (cap2 !== exp || n2 !== FW) begin
      miscompares++;
      $display("FAIL timing_data: got %0d bits %h required %0d bits %h", n2, cap2, FW, exp);
    end
    vectors++;
    if (ckhi2 !== FW) begin
      miscompares++;
      $display("FAIL timing_ck_high: got %0d cycles required %0d", ckhi2, FW);
    end
    vectors++;
    if (busy2 !== BUSY2 || rstlo2 !== 4) begin
      miscompares++;
      $display("FAIL timing_busy_rstb: got busy %0d rstb_low %0d required %0d and 4", busy2, rstlo2, BUSY2);
    end
    vectors++;
    if (viol2 !== 0) begin
      miscompares++;
      $display("FAIL timing_sr_in_stable: got %0d required 0", viol2);
    end
  endtask

  task automatic test_handshake();
    clear_stats();
    if1.In_Set_SC = 1'b1;
    wait_idle1("handshake_1");
    repeat (5) @(negedge clk);
    vectors++;
    if (load1 !== 4 || fin1 !== 2 || fin_first1 !== load_last1 + 1) begin
      miscompares++;
      $display("FAIL hs_load_finish: got load %0d fin %0d fin_first %0d load_last %0d required 4 2 and adjacent",
               load1, fin1, fin_first1, load_last1);
    end
    vectors++;
    if (load_r1 !== 1 || busy_r1 !== 1 || if1.Out_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_level_one_load: got loads %0d starts %0d busy %b required 1 1 0", load_r1, busy_r1, if1.Out_Busy);
    end
    if1.In_Set_SC = 1'b0; @(negedge clk);
    if1.In_Set_SC = 1'b1; @(negedge clk);
    vectors++;
    if (if1.Out_Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_rearm_start: got busy %b required 1", if1.Out_Busy);
    end
    if1.In_Set_SC = 1'b0;
    wait_idle1("handshake_2");
    vectors++;
    if (load_r1 !== 2 || fin_r1 !== 2) begin
      miscompares++;
      $display("FAIL hs_second_load: got loads %0d finishes %0d required 2 2", load_r1, fin_r1);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    clear_stats();
    pulse1();
    @(negedge clk);
    while (if1.Out_Busy !== 1'b0 && k < BOUND) begin @(negedge clk); k++; end
    // first IDLE cycle: raise the next request right away
    if1.In_Set_SC = 1'b1;
    @(negedge clk);
    if1.In_Set_SC = 1'b0;
    vectors++;
    if (if1.Out_Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy %b required 1", if1.Out_Busy);
    end
    wait_idle1("b2b");
    vectors++;
    if (busy_r1 !== 2 || busy1 !== 2 * BUSY1 || fin_r1 !== 2) begin
      miscompares++;
      $display("FAIL b2b_counts: got starts %0d busy %0d fins %0d required 2 %0d 2", busy_r1, busy1, fin_r1, 2 * BUSY1);
    end
  endtask

  task automatic test_ignore_abort();
    logic [FW-1:0] exp;
    logic [5:0] obs;
    if1.In_Set_DAC   = 48'h0F0_E1D_2C3_B4A;
    if1.In_Mask_Code = {4{64'h0123_4567_89AB_CDEF}};
    exp = {48'h0F0_E1D_2C3_B4A, {4{64'h0123_4567_89AB_CDEF}}};
    clear_stats();
    pulse1();
    wait_bits1(50, "ignore_wait");
    pulse1();
    wait_idle1("ignore");
    vectors++;
    if (load_r1 !== 1 || busy1 !== BUSY1 || cap1 !== exp) begin
      miscompares++;
      $display("FAIL ignore_mid_shift: got loads %0d busy %0d data %h required 1 %0d %h", load_r1, busy1, cap1, BUSY1, exp);
    end
    clear_stats();
    pulse1();
    wait_bits1(100, "abort_wait");
    rst = 1'b1;
    @(negedge clk);
    obs = {u1_ck, u1_in, u1_rstb, u1_load, if1.Out_Finish_Sc, if1.Out_Busy};
    rst = 1'b0;
    vectors++;
    if (obs !== 6'b001000) begin
      miscompares++;
      $display("FAIL abort_outputs: got %b required 001000", obs);
    end
    repeat (1300) @(negedge clk);
    vectors++;
    if (fin_r1 !== 0 || load_r1 !== 0 || if1.Out_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_finish: got fins %0d loads %0d busy %b required 0 0 0", fin_r1, load_r1, if1.Out_Busy);
    end
    clear_stats();
    pulse1();
    wait_idle1("after_abort");
    vectors++;
    if (cap1 !== exp || n1 !== FW || fin_r1 !== 1) begin
      miscompares++;
      $display("FAIL after_abort_load: got %0d bits fins %0d data %h required %0d 1 %h", n1, fin_r1, cap1, FW, exp);
    end
  endtask

  task automatic test_snapshot();
    logic [FW-1:0] exp;
    if1.In_Set_DAC   = 48'h800_001_7FF_555;
    if1.In_Mask_Code = {16{16'hA50F}};
    exp = {48'h800_001_7FF_555, {16{16'hA50F}}};
    clear_stats();
    pulse1();
    wait_bits1(10, "snapshot_wait");
    if1.In_Mask_Code = '1;
    if1.In_Set_DAC   = '0;
    wait_idle1("snapshot");
    vectors++;
    if (cap1 !== exp) begin
      miscompares++;
      $display("FAIL snapshot_data: got %h required %h", cap1, exp);
    end
  endtask

  initial begin
    if1.In_Set_SC = 1'b0; if1.In_Set_DAC = '0; if1.In_Mask_Code = '0;
    if2.In_Set_SC = 1'b0; if2.In_Set_DAC = '0; if2.In_Mask_Code = '0;
    test_reset();
    test_frame();
    test_timing();
    test_handshake();
    test_back_to_back();
    test_ignore_abort();
    test_snapshot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
